axi_bram_responder: RTL and testbench
=====================================

// Module: axi_bram_responder
// PURPOSE
// AXI4 slave backed by on-chip block RAM; responder end of the AXI DDR master port driven by al_saqr.
// Stands in for the DDR4 controller on boards or bench setups without external DRAM, sitting directly on
// the synchronous (post-CDC) DDR bus. Serves one transaction at a time, supports FIXED and INCR bursts.
// PARAMETERS
// AXI_ADDR_WIDTH  64          address width
// AXI_DATA_WIDTH  64          data width; power of two, >=32
// AXI_ID_WIDTH    7           ID width; IDs echoed unchanged
// AXI_USER_WIDTH  1           user width; inputs ignored, RUSER/BUSER driven 0
// MEM_BYTES       65536       RAM size in bytes; power of two, multiple of AXI_DATA_WIDTH/8
// BASE_ADDR       'h8000_0000 byte address mapped to RAM offset 0
// PORTS
// clk_i      in   1            clock; all logic on rising edge
// rst_ni     in   1            reset, asynchronous, active-low
// aw_*       in/out            AW channel: awid,awaddr,awlen[8],awsize[3],awburst[2],awvalid in; awready out
// w_*        in/out            W channel: wdata,wstrb[DW/8],wlast,wvalid in; wready out
// b_*        out/in            B channel: bid,bresp[2],buser,bvalid out; bready in
// ar_*       in/out            AR channel: arid,araddr,arlen[8],arsize[3],arburst[2],arvalid in; arready out
// r_*        out/in            R channel: rid,rdata,rresp[2],rlast,ruser,rvalid out; rready in
// (awlock/cache/prot/qos, arlock/cache/prot/qos accepted and ignored)
// BEHAVIOUR
// - Reset: FSM=IDLE; awready,arready,wready,bvalid,rvalid,rlast=0; bid,rid,bresp,rresp,rdata=0; prio=write.
//   RAM contents not reset. Reset mid-transaction drops it silently; no B/R issued for it.
// - FSM: IDLE, WR_DATA, WR_RESP, RD_DATA. One outstanding transaction total.
// - IDLE: awready/arready high only in IDLE and only for the selected channel. Both valid same cycle ->
//   round-robin: grant side = prio, prio toggles after each grant. Only one valid -> that side granted.
//   AW handshake -> WR_DATA next cycle; AR handshake -> RD_DATA next cycle.
// - Decode at accept: off = addr - BASE_ADDR; in range iff addr>=BASE_ADDR and off<MEM_BYTES.
//   Error precedence: out of range -> DECERR(2'b11); else size>log2(DW/8) or burst==WRAP(2'b10) -> SLVERR(2'b10);
//   else OKAY. Error transactions never touch RAM.
// - Addressing: beat0 address aligned down to 2^size; INCR adds 2^size per beat, FIXED holds. RAM word index
//   = off[log2(MEM_BYTES)-1:log2(DW/8)], wraps modulo MEM_BYTES (no 4KB check). Narrow reads return full word.
// - WR_DATA: wready=1. Each W handshake writes wdata under wstrb same cycle (byte-granular). Beat counter from 0;
//   burst ends on beat awlen (len+1 beats). wlast must be 1 exactly on that beat; any mismatch -> bresp SLVERR
//   (if OKAY so far). Beats after wlast=1 early are not accepted: transaction ends at first wlast or beat awlen.
//   End -> WR_RESP; wready=0 from next cycle.
// - WR_RESP: bvalid=1, bid=awid, bresp latched; held stable until bready; handshake -> IDLE next cycle.
// - RD_DATA: first rvalid exactly 2 cycles after AR handshake (1-cycle RAM latency). rdata/rid/rresp/rlast held
//   stable while rvalid && !rready. With rready held 1, beats are back-to-back (prefetch/skid of one word).
//   rlast=1 on beat arlen. Error reads return rdata=0, rresp=error on every beat, still arlen+1 beats.
//   rlast handshake -> IDLE next cycle.
// - Zero-latency loop-free: no output depends combinationally on any *valid/*ready input.
// - Write followed by read to same address observes written data (RAM write completes before B).
// TESTING
// 1. INCR write awaddr=BASE+0x40,len=3,size=3, data 0x11..44, strb=FF -> bresp OKAY,bid echoed; read same -> 4 beats
//    0x11..0x44 OKAY, rlast on beat 3, first rvalid 2 cycles after AR handshake.
// 2. Narrow write size=0 at BASE+0x5, wdata=0xAB<<40, strb=0x20 -> only byte 5 changes; readback word shows 0xAB there.
// 3. araddr=BASE-8 len=1 -> 2 beats rdata=0,rresp=DECERR; awburst=WRAP in range -> bresp SLVERR, RAM unchanged.
// 4. awvalid&arvalid asserted together 4 times from reset -> grants W,R,W,R; all responses correct IDs.
// 5. Random rready/bready backpressure (50%) on len=15 bursts -> outputs stable while stalled, data matches model.
// 6. wlast on beat 1 of len=3 -> bresp SLVERR; assert rst_ni low mid read burst -> rvalid=0 async, IDLE after release.

Source files
------------

// File: rtl/axi_bram_responder.sv
// AXI4 slave backed by a block RAM, standing in for the DDR controller on the post-CDC DDR bus.
// Serves one transaction at a time (FIXED/INCR bursts); all outputs are registered.
module axi_bram_responder #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 7,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned MEM_BYTES      = 65536,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // AW
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic                        aw_lock_i,
  input  logic [3:0]                  aw_cache_i,
  input  logic [2:0]                  aw_prot_i,
  input  logic [3:0]                  aw_qos_i,
  input  logic [AXI_USER_WIDTH-1:0]   aw_user_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  // W
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  input  logic [AXI_USER_WIDTH-1:0]   w_user_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  // B
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  output logic [AXI_USER_WIDTH-1:0]   b_user_o,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  // AR
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  input  logic                        ar_lock_i,
  input  logic [3:0]                  ar_cache_i,
  input  logic [2:0]                  ar_prot_i,
  input  logic [3:0]                  ar_qos_i,
  input  logic [AXI_USER_WIDTH-1:0]   ar_user_i,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  // R
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic [AXI_USER_WIDTH-1:0]   r_user_o,
  output logic                        r_valid_o,
  input  logic                        r_ready_i
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned BW     = $clog2(STRB_W);
  localparam int unsigned OW     = $clog2(MEM_BYTES);
  localparam int unsigned WORDS  = MEM_BYTES / STRB_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  state_e                      state_q;
  logic                        prio_q;        // 0: write side wins a tie, 1: read side
  logic                        aw_ready_q, ar_ready_q, w_ready_q;
  logic                        b_valid_q;
  logic [AXI_ID_WIDTH-1:0]     b_id_q, r_id_q;
  logic [1:0]                  b_resp_q, r_resp_q;
  logic                        r_valid_q, r_last_q;
  logic [AXI_DATA_WIDTH-1:0]   r_data_q;
  logic                        dec_err_q;
  logic [7:0]                  len_q, cnt_q;
  logic [2:0]                  size_q;
  logic [1:0]                  burst_q;
  logic [OW-1:0]               off_q, off_d;
  logic                        rd_wait_q, rd_done_q;

  logic [AXI_DATA_WIDTH-1:0]   mem [WORDS];

  logic [AXI_ADDR_WIDTH-1:0]   dec_addr, dec_off;
  logic [2:0]                  dec_size;
  logic [1:0]                  dec_burst, dec_resp;
  logic [OW-1:0]               dec_start;
  logic                        aw_hs, ar_hs, w_hs, wr_en, rd_load, beat_last, w_end;

  // Decode whichever address channel currently holds the ready; only one can.
  always_comb begin
    dec_addr  = ar_ready_q ? ar_addr_i  : aw_addr_i;
    dec_size  = ar_ready_q ? ar_size_i  : aw_size_i;
    dec_burst = ar_ready_q ? ar_burst_i : aw_burst_i;
    dec_off   = dec_addr - BASE_ADDR;
    if (dec_addr < BASE_ADDR || dec_off >= AXI_ADDR_WIDTH'(MEM_BYTES))
      dec_resp = RESP_DECERR;
    else if (dec_size > 3'(BW) || dec_burst == BURST_WRAP)
      dec_resp = RESP_SLVERR;
    else
      dec_resp = RESP_OKAY;
    dec_start = dec_off[OW-1:0] & ~((OW'(1) << dec_size) - OW'(1));
  end

  assign off_d     = (burst_q == BURST_FIXED) ? off_q : off_q + (OW'(1) << size_q);
  assign aw_hs     = (state_q == IDLE) && aw_ready_q && aw_valid_i;
  assign ar_hs     = (state_q == IDLE) && ar_ready_q && ar_valid_i;
  assign w_hs      = (state_q == WR_DATA) && w_ready_q && w_valid_i;
  assign wr_en     = w_hs && !dec_err_q;
  assign beat_last = (cnt_q == len_q);
  assign w_end     = w_last_i || beat_last;
  assign rd_load   = (state_q == RD_DATA) && !rd_wait_q && !rd_done_q && (!r_valid_q || r_ready_i);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_i[b]) mem[off_q[OW-1:BW]][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      dec_err_q  <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      off_q      <= '0;
      rd_wait_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_hs) begin
            aw_ready_q <= 1'b0;
            prio_q     <= ~prio_q;
            w_ready_q  <= 1'b1;
            b_id_q     <= aw_id_i;
            b_resp_q   <= dec_resp;
            dec_err_q  <= (dec_resp != RESP_OKAY);
            len_q      <= aw_len_i;
            size_q     <= aw_size_i;
            burst_q    <= aw_burst_i;
            off_q      <= dec_start;
            cnt_q      <= '0;
            state_q    <= WR_DATA;
          end else if (ar_hs) begin
            ar_ready_q <= 1'b0;
            prio_q     <= ~prio_q;
            r_id_q     <= ar_id_i;
            r_resp_q   <= dec_resp;
            dec_err_q  <= (dec_resp != RESP_OKAY);
            len_q      <= ar_len_i;
            size_q     <= ar_size_i;
            burst_q    <= ar_burst_i;
            off_q      <= dec_start;
            cnt_q      <= '0;
            rd_wait_q  <= 1'b1;
            rd_done_q  <= 1'b0;
            state_q    <= RD_DATA;
          end else if (!aw_ready_q && !ar_ready_q) begin
            // A raised ready is held until its (sticky) valid completes the handshake.
            if (aw_valid_i && (!ar_valid_i || !prio_q)) aw_ready_q <= 1'b1;
            else if (ar_valid_i)                         ar_ready_q <= 1'b1;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            if ((w_last_i != beat_last) && (b_resp_q == RESP_OKAY)) b_resp_q <= RESP_SLVERR;
            if (w_end) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              state_q   <= WR_RESP;
            end else begin
              cnt_q <= cnt_q + 8'd1;
              off_q <= off_d;
            end
          end
        end
        WR_RESP: begin
          if (b_ready_i) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RD_DATA: begin
          rd_wait_q <= 1'b0;   // one-cycle address stage before the first RAM read
          if (rd_load) begin
            r_valid_q <= 1'b1;
            r_data_q  <= dec_err_q ? '0 : mem[off_q[OW-1:BW]];
            r_last_q  <= beat_last;
            rd_done_q <= beat_last;
            cnt_q     <= cnt_q + 8'd1;
            off_q     <= off_d;
          end else if (r_valid_q && r_ready_i) begin
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            if (r_last_q) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign ar_ready_o = ar_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = b_id_q;
  assign b_resp_o   = b_resp_q;
  assign b_user_o   = '0;
  assign r_valid_o  = r_valid_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign r_last_o   = r_last_q;
  assign r_user_o   = '0;

  logic unused_inputs;
  assign unused_inputs = ^{aw_lock_i, aw_cache_i, aw_prot_i, aw_qos_i, aw_user_i, w_user_i,
                           ar_lock_i, ar_cache_i, ar_prot_i, ar_qos_i, ar_user_i};

endmodule

// File: tb/tb_axi_bram_responder.sv
// Directed bench for axi_bram_responder: writes, reads, decode errors, arbitration,
// backpressure, early wlast and asynchronous reset during a read burst.
module tb_axi_bram_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  aw_id = '0, ar_id = '0;
  logic [63:0] aw_addr = '0, ar_addr = '0;
  logic [7:0]  aw_len = '0, ar_len = '0;
  logic [2:0]  aw_size = '0, ar_size = '0;
  logic [1:0]  aw_burst = '0, ar_burst = '0;
  logic        aw_valid = 1'b0, ar_valid = 1'b0;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_last = 1'b0, w_valid = 1'b0, b_ready = 1'b0, r_ready = 1'b0;
  logic        aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o;
  logic [6:0]  b_id_o, r_id_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic [0:0]  b_user_o, r_user_o;
  logic [63:0] r_data_o;

  axi_bram_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_burst_i(aw_burst), .aw_lock_i(1'b0), .aw_cache_i(4'h0), .aw_prot_i(3'h0),
    .aw_qos_i(4'h0), .aw_user_i(1'b0), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_user_i(1'b0),
    .w_valid_i(w_valid), .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_user_o(b_user_o), .b_valid_o(b_valid_o),
    .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
    .ar_burst_i(ar_burst), .ar_lock_i(1'b0), .ar_cache_i(4'h0), .ar_prot_i(3'h0),
    .ar_qos_i(4'h0), .ar_user_i(1'b0), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_user_o(r_user_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready)
  );

  int n_assert = 0, n_fail = 0;
  logic [63:0] wbeats [16];
  logic [7:0]  wstrbs [16];
  logic [63:0] rexp   [16];
  logic [63:0] model  [int unsigned];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned beat_widx(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    logic [63:0] a;
    a = addr & ~((64'd1 << size) - 64'd1);
    if (burst == INCR) a = a + 64'(i) * (64'd1 << size);
    return 32'((a - BASE) >> 3) & 32'd8191;
  endfunction

  function automatic void model_wr(input int unsigned widx, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] cur;
    cur = model.exists(widx) ? model[widx] : 64'd0;
    for (int b = 0; b < 8; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    model[widx] = cur;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_aw(input logic [6:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
    while (!aw_ready_o && t < 50) begin @(negedge clk); t++; end
    check("aw_handshake_bound", 64'(t < 50), 64'd1);
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [6:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
    while (!ar_ready_o && t < 50) begin @(negedge clk); t++; end
    check("ar_handshake_bound", 64'(t < 50), 64'd1);
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic w_phase(input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      int t = 0;
      w_data = wbeats[i]; w_strb = wstrbs[i]; w_last = (i == last_at); w_valid = 1'b1;
      while (!w_ready_o && t < 50) begin @(negedge clk); t++; end
      check("w_beat_bound", 64'(t < 50), 64'd1);
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    check("w_ready_drop", 64'(w_ready_o), 64'd0);
  endtask

  task automatic b_phase(input logic [6:0] id, input logic [1:0] resp, input bit bp);
    int t = 0;
    while (!b_valid_o && t < 50) begin @(negedge clk); t++; end
    check("b_valid_bound", 64'(t < 50), 64'd1);
    if (bp) repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      check("b_stable", 64'({b_valid_o, b_resp_o, b_id_o}), 64'({1'b1, resp, id}));
    end
    check("b_id", 64'(b_id_o), 64'(id));
    check("b_resp", 64'(b_resp_o), 64'(resp));
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check("b_done", 64'(b_valid_o), 64'd0);
  endtask

  // Entered on the negedge right after the AR handshake edge.
  task automatic r_phase(input logic [6:0] id, input int len, input logic [1:0] resp, input bit bp);
    logic [63:0] sd = '0;
    logic [10:0] sc = '0;
    bit stall = 1'b0;
    int beats = 0, cyc = 0;
    check("r_lat0", 64'(r_valid_o), 64'd0);
    @(negedge clk);
    check("r_lat1", 64'(r_valid_o), 64'd0);
    while (beats <= len && cyc < 400) begin
      @(negedge clk); cyc++;
      if (cyc == 1) check("r_lat2", 64'(r_valid_o), 64'd1);
      if (stall) begin
        check("r_stable_data", r_data_o, sd);
        check("r_stable_ctl", 64'({r_valid_o, r_last_o, r_resp_o, r_id_o}), 64'(sc));
      end
      r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = 1'b0;
      if (r_valid_o) begin
        if (r_ready) begin
          check("r_data", r_data_o, rexp[beats]);
          check("r_resp", 64'(r_resp_o), 64'(resp));
          check("r_id", 64'(r_id_o), 64'(id));
          check("r_last", 64'(r_last_o), 64'(beats == len));
          beats++;
        end else begin
          stall = 1'b1; sd = r_data_o; sc = {r_valid_o, r_last_o, r_resp_o, r_id_o};
        end
      end
    end
    check("r_beat_count", 64'(beats), 64'(len + 1));
    if (!bp) check("r_back_to_back", 64'(cyc), 64'(len + 1));
    @(negedge clk);
    r_ready = 1'b0;
    check("r_done", 64'(r_valid_o), 64'd0);
  endtask

  task automatic wr(input logic [6:0] id, input logic [63:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input int nbeats, input int last_at,
                    input logic [1:0] resp, input bit bp, input bit upd);
    do_aw(id, addr, len, size, burst);
    w_phase(nbeats, last_at);
    b_phase(id, resp, bp);
    if (upd) for (int i = 0; i < nbeats; i++) model_wr(beat_widx(addr, size, burst, i), wbeats[i], wstrbs[i]);
  endtask

  task automatic rd(input logic [6:0] id, input logic [63:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp,
                    input bit bp, input bit use_model);
    if (use_model) for (int i = 0; i <= int'(len); i++) begin
      int unsigned w = beat_widx(addr, size, burst, i);
      rexp[i] = model.exists(w) ? model[w] : 64'd0;
    end
    do_ar(id, addr, len, size, burst);
    r_phase(id, int'(len), resp, bp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_aw_ready", 64'(aw_ready_o), 64'd0);
    check("rst_ar_ready", 64'(ar_ready_o), 64'd0);
    check("rst_w_ready", 64'(w_ready_o), 64'd0);
    check("rst_valids", 64'({b_valid_o, r_valid_o, r_last_o}), 64'd0);
    check("rst_ids_resps", 64'({b_id_o, r_id_o, b_resp_o, r_resp_o}), 64'd0);
    check("rst_r_data", r_data_o, 64'd0);

    // Simultaneous AW/AR four times from reset: grants alternate W, R, W, R.
    for (int r = 0; r < 4; r++) begin
      int t = 0;
      bit gw;
      wbeats[0] = 64'hA0 + 64'(r); wstrbs[0] = 8'hFF;
      aw_id = 7'h10 + 7'(r); aw_addr = BASE + 64'h100 + 64'(8 * (r / 2));
      aw_len = 8'd0; aw_size = 3'd3; aw_burst = INCR;
      ar_id = 7'h20 + 7'(r); ar_addr = BASE + 64'h100 + 64'(8 * (r / 2));
      ar_len = 8'd0; ar_size = 3'd3; ar_burst = INCR;
      aw_valid = 1'b1; ar_valid = 1'b1;
      while (!aw_ready_o && !ar_ready_o && t < 50) begin @(negedge clk); t++; end
      check("arb_bound", 64'(t < 50), 64'd1);
      check("arb_grant_write", 64'(aw_ready_o), 64'(r % 2 == 0));
      check("arb_exclusive", 64'(aw_ready_o & ar_ready_o), 64'd0);
      gw = aw_ready_o;
      @(negedge clk);
      aw_valid = 1'b0; ar_valid = 1'b0;
      if (gw) begin
        w_phase(1, 0);
        b_phase(7'h10 + 7'(r), OKAY, 1'b0);
        model_wr(beat_widx(BASE + 64'h100 + 64'(8 * (r / 2)), 3'd3, INCR, 0), wbeats[0], wstrbs[0]);
      end else begin
        rexp[0] = 64'hA0 + 64'(r - 1);
        r_phase(7'h20 + 7'(r), 0, OKAY, 1'b0);
      end
    end

    // INCR write then read back.
    wbeats[0] = 64'h11; wbeats[1] = 64'h22; wbeats[2] = 64'h33; wbeats[3] = 64'h44;
    for (int i = 0; i < 4; i++) wstrbs[i] = 8'hFF;
    wr(7'h05, BASE + 64'h40, 8'd3, 3'd3, INCR, 4, 3, OKAY, 1'b0, 1'b1);
    rexp[0] = 64'h11; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    rd(7'h06, BASE + 64'h40, 8'd3, 3'd3, INCR, OKAY, 1'b0, 1'b0);

    // Narrow single-byte write into a known word.
    wbeats[0] = 64'h0706_0504_0302_0100; wstrbs[0] = 8'hFF;
    wr(7'h01, BASE, 8'd0, 3'd3, INCR, 1, 0, OKAY, 1'b0, 1'b1);
    wbeats[0] = 64'hAB << 40; wstrbs[0] = 8'h20;
    wr(7'h02, BASE + 64'h5, 8'd0, 3'd0, INCR, 1, 0, OKAY, 1'b0, 1'b1);
    rexp[0] = 64'h0706_AB04_0302_0100;
    rd(7'h03, BASE, 8'd0, 3'd3, INCR, OKAY, 1'b0, 1'b0);

    // Decode and slave errors.
    rexp[0] = 64'd0; rexp[1] = 64'd0;
    rd(7'h07, BASE - 64'd8, 8'd1, 3'd3, INCR, DECERR, 1'b0, 1'b0);
    wbeats[0] = 64'hDEAD_BEEF_DEAD_BEEF; wbeats[1] = 64'hCAFE_CAFE_CAFE_CAFE;
    wstrbs[0] = 8'hFF; wstrbs[1] = 8'hFF;
    wr(7'h08, BASE + 64'h40, 8'd1, 3'd3, WRAP, 2, 1, SLVERR, 1'b0, 1'b0);
    wr(7'h09, BASE + 64'h1_0000, 8'd0, 3'd3, INCR, 1, 0, DECERR, 1'b0, 1'b0);
    rexp[0] = 64'h11; rexp[1] = 64'h22;
    rd(7'h0A, BASE + 64'h40, 8'd1, 3'd3, INCR, OKAY, 1'b0, 1'b0);
    rexp[0] = 64'd0;
    rd(7'h0B, BASE + 64'h40, 8'd0, 3'd4, INCR, SLVERR, 1'b0, 1'b0);

    // FIXED burst accumulates into one word; narrow read returns the aligned full word.
    wbeats[0] = 64'h1111_1111_1111_1111; wstrbs[0] = 8'hFF;
    wbeats[1] = 64'h2222_2222_2222_2222; wstrbs[1] = 8'h0F;
    wbeats[2] = 64'h3333_3333_3333_3333; wstrbs[2] = 8'hC0;
    wr(7'h0C, BASE + 64'h300, 8'd2, 3'd3, FIXED, 3, 2, OKAY, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) rexp[i] = 64'h3333_1111_2222_2222;
    rd(7'h0D, BASE + 64'h300, 8'd2, 3'd3, FIXED, OKAY, 1'b0, 1'b0);
    rd(7'h0E, BASE + 64'h303, 8'd0, 3'd2, INCR, OKAY, 1'b0, 1'b0);

    // Long bursts under random backpressure.
    for (int i = 0; i < 16; i++) begin
      wbeats[i] = {$urandom(), $urandom()}; wstrbs[i] = 8'hFF;
    end
    wr(7'h31, BASE + 64'h200, 8'd15, 3'd3, INCR, 16, 15, OKAY, 1'b1, 1'b1);
    rd(7'h32, BASE + 64'h200, 8'd15, 3'd3, INCR, OKAY, 1'b1, 1'b1);
    rd(7'h33, BASE + 64'h208, 8'd15, 3'd3, INCR, OKAY, 1'b1, 1'b1);

    // Early wlast.
    wbeats[0] = 64'h5555; wbeats[1] = 64'h6666; wstrbs[0] = 8'hFF; wstrbs[1] = 8'hFF;
    wr(7'h40, BASE + 64'h400, 8'd3, 3'd3, INCR, 2, 1, SLVERR, 1'b0, 1'b1);

    // Reset in the middle of a read burst.
    do_ar(7'h41, BASE + 64'h200, 8'd7, 3'd3, INCR);
    r_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rd_valid", 64'(r_valid_o), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rvalid", 64'(r_valid_o), 64'd0);
    check("async_rst_rlast", 64'(r_last_o), 64'd0);
    r_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'({r_valid_o, b_valid_o, w_ready_o}), 64'd0);
    rexp[0] = 64'h11;
    rd(7'h42, BASE + 64'h40, 8'd0, 3'd3, INCR, OKAY, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
